// File: rtl/cache_pkg.sv
// Shared state encoding and address geometry for the direct-mapped cache controller.
// Geometry comes from CACHE_T/CACHE_S/CACHE_B (defaulted here when not supplied).
`ifndef CACHE_T
`define CACHE_T 22
`endif
`ifndef CACHE_S
`define CACHE_S 6
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

package cache_pkg;
  localparam int TAG_W  = `CACHE_T;
  localparam int SET_W  = `CACHE_S;
  localparam int OFF_W  = `CACHE_B;
  localparam int WORD_W = OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  function automatic int words_per_line(input int off_w);
    return 1 << (off_w - 2);
  endfunction
endpackage

// File: rtl/cache_addr_split.sv
// Combinational split of a CPU byte address into tag, set index and word-in-line.
module cache_addr_split
  import cache_pkg::*;
#(
  parameter int TAG_WIDTH    = TAG_W,
  parameter int SET_WIDTH    = SET_W,
  parameter int OFFSET_WIDTH = OFF_W
) (
  input  logic [31:0]             addr_i,
  output logic [TAG_WIDTH-1:0]    tag_o,
  output logic [SET_WIDTH-1:0]    set_o,
  output logic [OFFSET_WIDTH-3:0] word_o,
  output logic                    misaligned_o
);
  assign tag_o        = addr_i[31 -: TAG_WIDTH];
  assign set_o        = addr_i[OFFSET_WIDTH +: SET_WIDTH];
  assign word_o       = addr_i[OFFSET_WIDTH-1:2];
  assign misaligned_o = |addr_i[1:0];
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: hit path, victim writeback, refill.
// Optional hit/miss statistics counters are built only when CACHE_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_WIDTH    = TAG_W,
  parameter int SET_WIDTH    = SET_W,
  parameter int OFFSET_WIDTH = OFF_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_wen,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic [SET_WIDTH-1:0]    line_set,
  output logic [OFFSET_WIDTH-3:0] line_offset,
  output logic                    line_w_en,
  output logic                    line_set_valid,
  output logic                    line_set_dirty,
  output logic [TAG_WIDTH-1:0]    line_set_tag,
  output logic [31:0]             line_write_data,
  input  logic                    line_valid,
  input  logic                    line_dirty,
  input  logic [TAG_WIDTH-1:0]    line_tag,
  input  logic [31:0]             line_read_data,
  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);
  localparam int WCW = OFFSET_WIDTH - 2;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(words_per_line(OFFSET_WIDTH) - 1);

  logic [TAG_WIDTH-1:0] tag;
  logic [SET_WIDTH-1:0] set;
  logic [WCW-1:0]       word;
  logic                 misaligned;
  logic                 hit;
  state_e               state_q, state_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;

  cache_addr_split #(
    .TAG_WIDTH   (TAG_WIDTH),
    .SET_WIDTH   (SET_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH)
  ) u_split (
    .addr_i      (cpu_addr),
    .tag_o       (tag),
    .set_o       (set),
    .word_o      (word),
    .misaligned_o(misaligned)
  );

  assign line_set = set;
  assign hit      = cpu_req & line_valid & (line_tag == tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Everything is gated by reset so outputs drop combinationally, not at the next edge.
  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    cpu_ready       = 1'b0;
    cpu_rdata       = '0;
    line_offset     = word;
    line_w_en       = 1'b0;
    line_set_valid  = 1'b0;
    line_set_dirty  = 1'b0;
    line_set_tag    = '0;
    line_write_data = '0;
    mem_req         = 1'b0;
    mem_wen         = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              cpu_ready = 1'b1;
              if (cpu_wen) begin
                line_w_en       = 1'b1;
                line_set_tag    = tag;
                line_set_valid  = 1'b1;
                line_set_dirty  = 1'b1;
                line_write_data = cpu_wdata;
              end else begin
                cpu_rdata = line_read_data;
              end
            end else begin
              wcnt_d  = '0;
              state_d = (line_valid && line_dirty) ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          line_offset = wcnt_q;
          mem_req     = 1'b1;
          mem_wen     = 1'b1;
          mem_addr    = {line_tag, set, wcnt_q, 2'b00};
          mem_wdata   = line_read_data;
          if (mem_ready) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST_WORD) begin
              wcnt_d  = '0;
              state_d = REFILL;
            end
          end
        end
        REFILL: begin
          line_offset = wcnt_q;
          mem_req     = 1'b1;
          mem_addr    = {tag, set, wcnt_q, 2'b00};
          if (mem_ready) begin
            line_w_en       = 1'b1;
            line_write_data = mem_rdata;
            line_set_tag    = tag;
            line_set_valid  = 1'b1;
            wcnt_d          = wcnt_q + 1'b1;
            if (wcnt_q == LAST_WORD) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        hit_evt, miss_evt;
  assign hit_evt  = !reset && (state_q == IDLE) && hit;
  assign miss_evt = !reset && (state_q == IDLE) && cpu_req && !hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_evt)  hit_q  <= hit_q + 32'd1;
      if (miss_evt) miss_q <= miss_q + 32'd1;
    end
  end
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  // The access must stay presented for the whole miss sequence.
  a_req_held: assert property (@(posedge clk) disable iff (reset) (state_q != IDLE) |-> cpu_req);
  a_aligned:  assert property (@(posedge clk) disable iff (reset) cpu_req |-> !misaligned);
endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: models the line array and a word memory with adjustable latency.
module tb_cache_ctrl;
  import cache_pkg::*;
  localparam int TW = TAG_W, SW = SET_W, OW = OFF_W, WW = OW - 2, W = 1 << WW;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_wen = 1'b0, cpu_ready;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic [SW-1:0] line_set;
  logic [WW-1:0] line_offset;
  logic line_w_en, line_set_valid, line_set_dirty, line_valid, line_dirty;
  logic [TW-1:0] line_set_tag, line_tag;
  logic [31:0] line_write_data, line_read_data;
  logic mem_req, mem_wen, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, hit_count, miss_count;

  cache_ctrl dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .line_set(line_set),
    .line_offset(line_offset), .line_w_en(line_w_en), .line_set_valid(line_set_valid),
    .line_set_dirty(line_set_dirty), .line_set_tag(line_set_tag), .line_write_data(line_write_data),
    .line_valid(line_valid), .line_dirty(line_dirty), .line_tag(line_tag),
    .line_read_data(line_read_data), .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Line array model: combinational read, write on clock, valid/dirty cleared by reset.
  logic [31:0]   lmem_data  [2**SW][W];
  logic [TW-1:0] lmem_tag   [2**SW];
  logic          lmem_valid [2**SW];
  logic          lmem_dirty [2**SW];
  assign line_valid     = lmem_valid[line_set];
  assign line_dirty     = lmem_dirty[line_set];
  assign line_tag       = lmem_tag[line_set];
  assign line_read_data = lmem_data[line_set][line_offset];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**SW; i++) begin
        lmem_valid[i] <= 1'b0;
        lmem_dirty[i] <= 1'b0;
      end
    end else if (line_w_en) begin
      lmem_data[line_set][line_offset] <= line_write_data;
      lmem_tag[line_set]   <= line_set_tag;
      lmem_valid[line_set] <= line_set_valid;
      lmem_dirty[line_set] <= line_set_dirty;
    end
  end

  typedef struct packed {logic wen; logic [31:0] addr; logic [31:0] data;} beat_t;
  beat_t beat_q[$], exp_q[$];
  logic [31:0] exp_rd[$];
  int mem_lat = 0, wait_cnt = 0;
  int vectors = 0, errors = 0;
  int unsigned exp_hits = 0, exp_misses = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mk(input int t, input int s, input int w);
    return (32'(t) << (SW + OW)) | (32'(s) << OW) | (32'(w) << 2);
  endfunction

  // Memory responder: mem_lat idle cycles, then a one-cycle ready pulse per beat.
  always @(negedge clk) begin
    if (mem_req && !reset) begin
      if (wait_cnt >= mem_lat) begin
        mem_ready <= 1'b1;
        mem_rdata <= pat(mem_addr);
        beat_q.push_back({mem_wen, mem_addr, mem_wen ? mem_wdata : 32'h0});
        wait_cnt  <= 0;
      end else begin
        mem_ready <= 1'b0;
        wait_cnt  <= wait_cnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      wait_cnt  <= 0;
    end
  end

  task automatic cpu_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int cycles);
    cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; cycles = 0;
    #1;
    while (cpu_ready !== 1'b1 && cycles < 200) begin
      @(posedge clk); #1; cycles++;
    end
    rdata = cpu_rdata;
    vectors++;
    if (cpu_ready !== 1'b1) begin
      errors++; $display("FAIL access_timeout addr=%h got ready=%b want 1", addr, cpu_ready);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = mk(0, 4, 0);
    repeat (2) @(posedge clk);
    #1;
    vectors++; if ({cpu_ready, mem_req, line_w_en} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {cpu_ready, mem_req, line_w_en}); end
    vectors++; if (cpu_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
    vectors++; if ({hit_count, miss_count} !== 64'h0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count); end
    cpu_req = 1'b0; reset = 1'b0;
    exp_hits = 0; exp_misses = 0;
    @(posedge clk); #1;
    $display("reset: ready=%b mem_req=%b", cpu_ready, mem_req);
  endtask

  task automatic test_load_miss();
    logic [31:0] rd; int cyc; beat_t g, e; logic [31:0] er;
    beat_q.delete();
    for (int w = 0; w < W; w++) exp_q.push_back({1'b0, mk(0, 4, w), 32'h0});
    exp_rd.push_back(pat(mk(0, 4, 0)));
    cpu_access(1'b0, mk(0, 4, 0), 32'h0, rd, cyc);
    exp_misses++; exp_hits++;
    vectors++; if (beat_q.size() != exp_q.size()) begin
      errors++; $display("FAIL miss_beats got %0d want %0d", beat_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front(); g = beat_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL miss_beat got %h want %h", g, e); end
    end
    exp_q.delete();
    er = exp_rd.pop_front();
    vectors++; if (rd !== er) begin errors++; $display("FAIL miss_rdata got %h want %h", rd, er); end
    vectors++; if (cyc != W + 1) begin errors++; $display("FAIL miss_latency got %0d want %0d", cyc, W + 1); end
    vectors++; if (lmem_dirty[4] !== 1'b0 || lmem_data[4][1] !== pat(mk(0, 4, 1))) begin
      errors++; $display("FAIL miss_fill got d=%b w1=%h want d=0 w1=%h", lmem_dirty[4], lmem_data[4][1], pat(mk(0, 4, 1))); end
    vectors++; if (miss_count !== (STATS ? exp_misses : 0)) begin
      errors++; $display("FAIL miss_count got %0d want %0d", miss_count, STATS ? exp_misses : 0); end
    $display("load_miss: addr=%h rdata=%h cycles=%0d", mk(0, 4, 0), rd, cyc);
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; int cyc;
    beat_q.delete();
    cpu_access(1'b1, mk(0, 4, 1), 32'hDEAD_BEEF, rd, cyc);
    exp_hits++;
    vectors++; if (cyc != 0) begin errors++; $display("FAIL store_latency got %0d want 0", cyc); end
    vectors++; if (beat_q.size() != 0) begin errors++; $display("FAIL store_memreq got %0d beats want 0", beat_q.size()); end
    vectors++; if (lmem_data[4][1] !== 32'hDEAD_BEEF || lmem_dirty[4] !== 1'b1) begin
      errors++; $display("FAIL store_line got %h d=%b want deadbeef d=1", lmem_data[4][1], lmem_dirty[4]); end
    $display("store_hit: addr=%h cycles=%0d", mk(0, 4, 1), cyc);
  endtask

  task automatic test_writeback();
    logic [31:0] rd; int cyc; beat_t g, e; logic [31:0] er;
    beat_q.delete();
    for (int w = 0; w < W; w++)
      exp_q.push_back({1'b1, mk(0, 4, w), (w == 1) ? 32'hDEAD_BEEF : pat(mk(0, 4, w))});
    for (int w = 0; w < W; w++) exp_q.push_back({1'b0, mk(1, 4, w), 32'h0});
    exp_rd.push_back(pat(mk(1, 4, 0)));
    cpu_access(1'b0, mk(1, 4, 0), 32'h0, rd, cyc);
    exp_misses++; exp_hits++;
    vectors++; if (beat_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wb_beats got %0d want %0d", beat_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front(); g = beat_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL wb_beat got %h want %h", g, e); end
    end
    exp_q.delete();
    er = exp_rd.pop_front();
    vectors++; if (rd !== er) begin errors++; $display("FAIL wb_rdata got %h want %h", rd, er); end
    vectors++; if (cyc != 2 * W + 1) begin errors++; $display("FAIL wb_latency got %0d want %0d", cyc, 2 * W + 1); end
    vectors++; if (lmem_dirty[4] !== 1'b0 || lmem_tag[4] !== TW'(1)) begin
      errors++; $display("FAIL wb_line got d=%b tag=%h want d=0 tag=1", lmem_dirty[4], lmem_tag[4]); end
    $display("writeback: addr=%h rdata=%h cycles=%0d", mk(1, 4, 0), rd, cyc);
  endtask

  task automatic test_hits();
    logic [31:0] rd; int cyc;
    exp_rd.push_back(pat(mk(1, 4, 2)));
    cpu_access(1'b0, mk(1, 4, 2), 32'h0, rd, cyc);
    vectors++; if (rd !== exp_rd[0] || cyc != 0) begin
      errors++; $display("FAIL hit_load got %h/%0d want %h/0", rd, cyc, exp_rd[0]); end
    void'(exp_rd.pop_front());
    cpu_access(1'b1, mk(1, 4, 0), 32'h0BAD_F00D, rd, cyc);
    exp_rd.push_back(32'h0BAD_F00D);
    cpu_access(1'b0, mk(1, 4, 0), 32'h0, rd, cyc);
    vectors++; if (rd !== exp_rd[0] || cyc != 0) begin
      errors++; $display("FAIL hit_reload got %h/%0d want %h/0", rd, cyc, exp_rd[0]); end
    void'(exp_rd.pop_front());
    exp_hits += 3;
    vectors++; if (hit_count !== (STATS ? exp_hits : 0) || miss_count !== (STATS ? exp_misses : 0)) begin
      errors++; $display("FAIL stats got %0d/%0d want %0d/%0d", hit_count, miss_count,
                         STATS ? exp_hits : 0, STATS ? exp_misses : 0); end
    $display("hits: hit_count=%0d miss_count=%0d", hit_count, miss_count);
  endtask

  task automatic test_stall();
    logic [31:0] rd; int cyc; int n; bit done; beat_t g, e;
    beat_q.delete(); mem_lat = 5; n = 0; done = 1'b0;
    for (int w = 0; w < W; w++) exp_q.push_back({1'b0, mk(0, 8, w), 32'h0});
    fork
      begin cpu_access(1'b0, mk(0, 8, 0), 32'h0, rd, cyc); done = 1'b1; end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (mem_req === 1'b1) begin
            n++; vectors++;
            if (mem_addr !== mk(0, 8, beat_q.size())) begin
              errors++; $display("FAIL stall_addr got %h want %h", mem_addr, mk(0, 8, beat_q.size())); end
          end
        end
      end
    join
    mem_lat = 0; exp_misses++; exp_hits++;
    vectors++; if (n < 5 * W) begin errors++; $display("FAIL stall_req_held got %0d cycles want >=%0d", n, 5 * W); end
    vectors++; if (cyc != 1 + 6 * W) begin errors++; $display("FAIL stall_latency got %0d want %0d", cyc, 1 + 6 * W); end
    vectors++; if (rd !== pat(mk(0, 8, 0))) begin errors++; $display("FAIL stall_rdata got %h want %h", rd, pat(mk(0, 8, 0))); end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front(); g = beat_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL stall_beat got %h want %h", g, e); end
    end
    exp_q.delete();
    $display("stall: cycles=%0d req_samples=%0d", cyc, n);
  endtask

  task automatic test_reset_mid_wb();
    logic [31:0] rd; int cyc; int k; beat_t g, e;
    beat_q.delete();
    cpu_wen = 1'b0; cpu_addr = mk(2, 4, 0); cpu_req = 1'b1; k = 0;
    while (!(beat_q.size() == 2 && mem_req === 1'b1) && k < 50) begin @(posedge clk); #1; k++; end
    vectors++; if (mem_wen !== 1'b1 || mem_addr !== mk(1, 4, 2)) begin
      errors++; $display("FAIL rst_wb_beat2 got wen=%b addr=%h want 1/%h", mem_wen, mem_addr, mk(1, 4, 2)); end
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    vectors++; if ({mem_req, cpu_ready, line_w_en} !== 3'b000) begin
      errors++; $display("FAIL rst_async got %b want 000", {mem_req, cpu_ready, line_w_en}); end
    @(posedge clk); #1;
    reset = 1'b0; beat_q.delete(); exp_hits = 0; exp_misses = 0;
    @(posedge clk); #1;
    vectors++; if ({mem_req, cpu_ready} !== 2'b00 || {hit_count, miss_count} !== 64'h0) begin
      errors++; $display("FAIL rst_idle got req=%b rdy=%b cnt=%0d/%0d want 0", mem_req, cpu_ready, hit_count, miss_count); end
    for (int w = 0; w < W; w++) exp_q.push_back({1'b0, mk(2, 4, w), 32'h0});
    cpu_access(1'b0, mk(2, 4, 0), 32'h0, rd, cyc);
    exp_misses++; exp_hits++;
    vectors++; if (beat_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_refill_beats got %0d want %0d", beat_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      e = exp_q.pop_front(); g = beat_q.pop_front(); vectors++;
      if (g !== e) begin errors++; $display("FAIL rst_refill_beat got %h want %h", g, e); end
    end
    exp_q.delete();
    vectors++; if (hit_count !== (STATS ? exp_hits : 0) || miss_count !== (STATS ? exp_misses : 0)) begin
      errors++; $display("FAIL rst_stats got %0d/%0d want %0d/%0d", hit_count, miss_count,
                         STATS ? exp_hits : 0, STATS ? exp_misses : 0); end
    $display("reset_mid_wb: refill rdata=%h cycles=%0d", rd, cyc);
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_writeback();
    test_hits();
    test_stall();
    test_reset_mid_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller.
- Sits between the CPU memory port and the cache line array.
- Decodes CPU addresses and drives the per-line write/tag/valid/dirty interface.
- On a miss, sequences word-at-a-time writeback of a dirty victim and refill from memory.
- The line array is external; this block only drives the selected line and reads back its state.

Parameters:
- TAG_WIDTH, `CACHE_T: tag bits of address.
- SET_WIDTH, `CACHE_S: index bits; the array holds 2^SET_WIDTH lines.
- OFFSET_WIDTH, `CACHE_B: byte-offset bits per line; words per line W = 2^(OFFSET_WIDTH-2). TAG_WIDTH+SET_WIDTH+OFFSET_WIDTH = 32.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- cpu_req, input, 1: CPU access valid.
- cpu_wen, input, 1: 1 = store, 0 = load.
- cpu_addr, input, 32: byte address, word aligned.
- cpu_wdata, input, 32: store data.
- cpu_rdata, output, 32: load data, valid when cpu_ready.
- cpu_ready, output, 1: access completes this cycle.
- line_set, output, SET_WIDTH: selected line index.
- line_offset, output, OFFSET_WIDTH-2: word within line.
- line_w_en, line_set_valid, line_set_dirty, output, 1 each: line write controls.
- line_set_tag, output, TAG_WIDTH: tag to write.
- line_write_data, output, 32: word to write.
- line_valid, line_dirty, input, 1 each: selected line state.
- line_tag, input, TAG_WIDTH: selected line tag.
- line_read_data, input, 32: selected word.
- mem_req, output, 1: memory word request.
- mem_wen, output, 1: 1 = write.
- mem_addr, output, 32: word address.
- mem_wdata, output, 32: write data.
- mem_rdata, input, 32: read data.
- mem_ready, input, 1: one-cycle accept/complete pulse.
- hit_count, miss_count, output, 32 each: statistics (see Optional Feature).

Behaviour:
- Address split: tag = addr[31 -: TAG_WIDTH], set = addr[OFFSET_WIDTH +: SET_WIDTH], word = addr[OFFSET_WIDTH-1:2].
- line_set always equals the set field of cpu_addr.
- The CPU holds cpu_req, cpu_wen, cpu_addr and cpu_wdata stable until cpu_ready.
- States: IDLE, WRITEBACK, REFILL. A word counter wcnt is OFFSET_WIDTH-2 bits wide.
- IDLE:
  - hit = cpu_req & line_valid & (line_tag == tag).
  - Load hit: cpu_ready=1 and cpu_rdata=line_read_data in the same cycle (0-cycle latency).
  - Store hit: line_w_en=1, set_tag=tag, set_valid=1, set_dirty=1, write_data=cpu_wdata, and cpu_ready=1 in the same cycle.
  - Miss with line_valid & line_dirty: go to WRITEBACK, wcnt=0.
  - Miss otherwise: go to REFILL, wcnt=0.
  - No cpu_req: nothing happens.
- WRITEBACK:
  - line_offset=wcnt, mem_req=1, mem_wen=1.
  - mem_addr={line_tag, set, wcnt, 2'b00}, mem_wdata=line_read_data.
  - On mem_ready, wcnt increments. On mem_ready with wcnt==W-1: go to REFILL, wcnt=0 (wrap).
- REFILL:
  - line_offset=wcnt, mem_req=1, mem_wen=0, mem_addr={tag, set, wcnt, 2'b00}.
  - On mem_ready: line_w_en=1, write_data=mem_rdata, set_tag=tag, set_valid=1, set_dirty=0; wcnt increments.
  - After the last word: go to IDLE. The access is then re-evaluated and hits.
  - Load miss latency is therefore (W or 2W memory beats) + 1 cycle.
- Outside the states above: line_w_en=0, mem_req=0, cpu_ready=0.
- In IDLE, line_offset=word.
- mem_req stays high with a stable address until mem_ready; there are no gaps between beats.
- Reset, asynchronous at any time including mid-WRITEBACK or mid-REFILL: state=IDLE, wcnt=0.
  - All outputs deassert combinationally; cpu_rdata=0; counters=0.
  - A partially refilled line may remain valid, so the line array must be reset together with this block.
- cpu_req dropping mid-miss is illegal; behaviour is undefined and assertion-checked.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined: hit_count increments on each IDLE hit with cpu_ready; miss_count increments on each IDLE to WRITEBACK/REFILL transition. Both are 32-bit and wrap at 2^32.
- Otherwise: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum (IDLE/WRITEBACK/REFILL);
  - the address-field slice widths, derived from cache.vh constants;
  - a function returning words-per-line.
- One natural sub-module: cache_addr_split, a purely combinational decode of tag/set/word. The FSM stays in cache_ctrl.

Test Plan:
- Reset, then load 0x0000_0040 with all lines invalid → REFILL of W words at 0x40..0x40+4(W-1); then cpu_ready with cpu_rdata = memory word at 0x40; miss_count=1.
- Store 0xDEADBEEF to 0x44 right after the above → same-cycle cpu_ready; line write with dirty=1; no mem_req.
- Load from a conflicting address with the same set and a different tag → WRITEBACK writes 0xDEADBEEF to 0x44 first, then refill from the new address; line ends with dirty=0.
- mem_ready stalled for 5 cycles mid-REFILL → mem_addr and mem_req held stable and wcnt unchanged.
- Reset asserted during WRITEBACK beat 2 → next cycle state=IDLE, mem_req=0, wcnt=0, cpu_ready=0.
- With CACHE_STATS_EN: 3 hits + 2 misses → hit_count=3, miss_count=2; without the macro → both 0.
